seg7_scan_decoder: RTL and testbench

//  Receive end of the 7-segment display interface: samples multiplexed, active-high segment lines
//  (SEGA..SEGG) plus one-hot digit-select lines, recovers the hex value shown in each digit slot and

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_pattern_decode.sv | 22 ++
 rtl/seg7_scan_decoder.sv | 110 +++++++++++
 tb/tb_seg7_scan_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment tables and slot status for the display driver and the
// loopback decoder, so both ends agree on one pattern set.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_VALID,
    ST_BLANK,
    ST_ERR
  } slot_st_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Bit order {G,F,E,D,C,B,A}, index is the hex value shown.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_of(
    input logic [3:0] v
  );
    return SEG_TAB[v];
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to hex value plus slot status.
// Unknown non-blank patterns report value 0 with ST_ERR.
import seg7_pkg::*;

module seg7_pattern_decode (
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output slot_st_t   status
);

  always_comb begin
    value  = '0;
    status = (pattern == SEG_BLANK) ? ST_BLANK : ST_ERR;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TAB[i]) begin
        value  = 4'(i);
        status = ST_VALID;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment display: stability filter,
// per-slot capture registers and frame-complete pulse.
import seg7_pkg::*;

module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              EN,
  input  logic [NDIG-1:0]   AN,
  input  logic              SEGA,
  input  logic              SEGB,
  input  logic              SEGC,
  input  logic              SEGD,
  input  logic              SEGE,
  input  logic              SEGF,
  input  logic              SEGG,
  output logic [4*NDIG-1:0] DIGITS,
  output logic [NDIG-1:0]   DVALID,
  output logic [NDIG-1:0]   BLANK,
  output logic [NDIG-1:0]   ERR,
  output logic              FRAME
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [6:0]      seg;
  logic [NDIG-1:0] s_an;
  logic [6:0]      s_seg;
  logic            s_en;
  logic [3:0]      cnt;
  logic [NDIG-1:0] mask;
  logic [NDIG-1:0] mask_nxt;
  logic            changed;
  logic            onehot;
  logic            run;
  logic            cap;
  logic            full;
  logic [IW-1:0]   idx;
  logic [3:0]      value;
  slot_st_t        status;

  assign seg = {SEGG, SEGF, SEGE, SEGD,
                SEGC, SEGB, SEGA};

  // EN is sampled too, so a re-enable costs the same latency as new data.
  assign changed = (AN != s_an) ||
                   (seg != s_seg);
  assign onehot  = (s_an != '0) &&
                   ((s_an & (s_an - NDIG'(1))) == '0);
  assign run     = EN && s_en && onehot && !changed;
  assign cap     = run &&
                   (cnt == 4'(STABLE_CYC - 1));

  assign mask_nxt = mask | s_an;
  assign full     = &mask_nxt;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (s_an[i]) idx = idx | IW'(i);
    end
  end

  seg7_pattern_decode u_dec (
    .pattern (s_seg),
    .value   (value),
    .status  (status)
  );

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      s_an  <= '0;
      s_seg <= '0;
      s_en  <= 1'b0;
      cnt   <= '0;
    end else begin
      s_an  <= AN;
      s_seg <= seg;
      s_en  <= EN;
      if (!run)
        cnt <= '0;
      else if (cnt != 4'(STABLE_CYC))
        cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      DIGITS <= '0;
      DVALID <= '0;
      BLANK  <= '0;
      ERR    <= '0;
      FRAME  <= 1'b0;
      mask   <= '0;
    end else begin
      FRAME <= cap && full;
      if (cap) begin
        DIGITS[4*int'(idx) +: 4] <= value;
        DVALID[idx] <= (status == ST_VALID);
        BLANK[idx]  <= (status == ST_BLANK);
        ERR[idx]    <= (status == ST_ERR);
        mask        <= full ? '0 : mask_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a pin-level filter model
// predicts each capture edge and the full output snapshot.
module tb_seg7_scan_decoder;

  localparam int NDIG = 4;
  localparam int SC   = 4;

  logic        CLK     = 1'b0;
  logic        RESET_L = 1'b0;
  logic        EN      = 1'b0;
  logic [3:0]  AN      = '0;
  logic [6:0]  seg     = '0;
  logic [15:0] DIGITS;
  logic [3:0]  DVALID;
  logic [3:0]  BLANK;
  logic [3:0]  ERR;
  logic        FRAME;

  seg7_scan_decoder #(
    .NDIG       (NDIG),
    .STABLE_CYC (SC)
  ) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .EN      (EN),
    .AN      (AN),
    .SEGA    (seg[0]),
    .SEGB    (seg[1]),
    .SEGC    (seg[2]),
    .SEGD    (seg[3]),
    .SEGE    (seg[4]),
    .SEGF    (seg[5]),
    .SEGG    (seg[6]),
    .DIGITS  (DIGITS),
    .DVALID  (DVALID),
    .BLANK   (BLANK),
    .ERR     (ERR),
    .FRAME   (FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [15:0] dg;
    logic [3:0]  dv;
    logic [3:0]  bl;
    logic [3:0]  er;
    logic        fr;
  } exp_t;

  logic [6:0] pat [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          pos_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          frames  = 0;
  bit          mon_on  = 0;
  exp_t        q[$];
  exp_t        cur;
  exp_t        mon_e;
  logic [15:0] m_dg;
  logic [3:0]  m_dv, m_bl, m_er, m_mask;
  logic [11:0] prev;
  bit          prev_ok;
  int          run;

  always @(posedge CLK) pos_cnt++;

  always @(negedge CLK) begin
    if (RESET_L && mon_on) begin
      mon_e    = cur;
      mon_e.fr = 1'b0;
      if (q.size() > 0 && q[0].due == pos_cnt) begin
        mon_e  = q.pop_front();
        cur    = mon_e;
        cur.fr = 1'b0;
      end
      checks++;
      if ({DIGITS, DVALID, BLANK, ERR, FRAME} !==
          {mon_e.dg, mon_e.dv, mon_e.bl, mon_e.er, mon_e.fr}) begin
        errors++;
        $display("FAIL scoreboard edge %0d got dg=%h dv=%b bl=%b er=%b fr=%b want dg=%h dv=%b bl=%b er=%b fr=%b",
                 pos_cnt, DIGITS, DVALID, BLANK, ERR, FRAME,
                 mon_e.dg, mon_e.dv, mon_e.bl, mon_e.er, mon_e.fr);
      end
      if (FRAME) frames++;
    end
  end

  task automatic model_reset();
    m_dg    = '0;
    m_dv    = '0;
    m_bl    = '0;
    m_er    = '0;
    m_mask  = '0;
    prev    = '0;
    prev_ok = 0;
    run     = 0;
    q.delete();
    cur = '{default: '0};
  endtask

  task automatic capture(input int due, input logic [3:0] an,
                         input logic [6:0] sg);
    exp_t       e;
    int         slot;
    bit         hit;
    logic [3:0] v;
    logic [3:0] nm;
    slot = 0;
    for (int i = 0; i < 4; i++) if (an[i]) slot = i;
    hit = 0;
    v   = '0;
    for (int i = 0; i < 16; i++)
      if (pat[i] == sg) begin hit = 1; v = 4'(i); end
    m_dg[4*slot +: 4] = v;
    m_dv[slot] = hit;
    m_bl[slot] = !hit && (sg == 7'h00);
    m_er[slot] = !hit && (sg != 7'h00);
    nm   = m_mask | an;
    e.fr = (nm == 4'hF);
    m_mask = e.fr ? 4'h0 : nm;
    e.due = due;
    e.dg  = m_dg;
    e.dv  = m_dv;
    e.bl  = m_bl;
    e.er  = m_er;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] sg,
                       input logic en, input int n);
    logic [11:0] pins;
    bit          legal;
    int          k;
    @(negedge CLK);
    AN  = an;
    seg = sg;
    EN  = en;
    k   = pos_cnt;
    pins  = {en, an, sg};
    legal = en && ($countones(an) == 1);
    for (int j = 1; j <= n; j++) begin
      if (!legal) run = 0;
      else if (prev_ok && pins == prev) run++;
      else run = 1;
      prev    = pins;
      prev_ok = 1;
      if (run == SC + 1) capture(k + j, an, sg);
    end
    repeat (n) @(posedge CLK);
  endtask

  task automatic test_reset();
    checks++;
    if ({DIGITS, DVALID, BLANK, ERR, FRAME} !== 29'h0) begin
      errors++;
      $display("FAIL reset_state got %h want 0",
               {DIGITS, DVALID, BLANK, ERR, FRAME});
    end
    @(negedge CLK);
    RESET_L = 1'b1;
    mon_on  = 1;
    drive(4'b0001, 7'h4F, 1'b1, 6);
    checks++;
    if (DIGITS[3:0] !== 4'h3 || DVALID[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got %h/%b want 3/1", DIGITS[3:0], DVALID[0]);
    end
    drive(4'b0010, 7'h06, 1'b1, 3);
    mon_on = 0;
    #2 RESET_L = 1'b0;
    #1;
    checks++;
    if ({DIGITS, DVALID, BLANK, ERR, FRAME} !== 29'h0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {DIGITS, DVALID, BLANK, ERR, FRAME});
    end
    @(negedge CLK);
    AN  = '0;
    seg = '0;
    EN  = 1'b0;
    model_reset();
    @(negedge CLK);
    RESET_L = 1'b1;
    mon_on  = 1;
    drive(4'b0000, 7'h00, 1'b0, 8);
    checks++;
    if (frames != 0) begin
      errors++;
      $display("FAIL reset_frame got %0d pulses want 0", frames);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      drive(4'b0001, pat[v], 1'b1, 6);
      checks++;
      if (DIGITS[3:0] !== 4'(v) || DVALID[0] !== 1'b1) begin
        errors++;
        $display("FAIL sweep_%0d got %h/%b want %h/1",
                 v, DIGITS[3:0], DVALID[0], 4'(v));
      end
    end
  endtask

  task automatic test_glitch();
    drive(4'b0010, 7'h06, 1'b1, 3);
    drive(4'b0010, 7'h5B, 1'b1, 6);
    checks++;
    if (DIGITS[7:4] !== 4'h2 || DVALID[1] !== 1'b1) begin
      errors++;
      $display("FAIL glitch got %h/%b want 2/1", DIGITS[7:4], DVALID[1]);
    end
  endtask

  task automatic test_illegal();
    drive(4'b0100, 7'h49, 1'b1, 6);
    checks++;
    if (ERR[2] !== 1'b1 || DVALID[2] !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pat got err=%b dv=%b want 1/0", ERR[2], DVALID[2]);
    end
    drive(4'b0100, 7'h00, 1'b1, 6);
    checks++;
    if (BLANK[2] !== 1'b1 || ERR[2] !== 1'b0) begin
      errors++;
      $display("FAIL blank_pat got bl=%b err=%b want 1/0", BLANK[2], ERR[2]);
    end
  endtask

  task automatic test_frame();
    int f0;
    f0 = frames;
    for (int i = 0; i < 4; i++)
      drive(4'(1 << i), pat[i], 1'b1, 6);
    checks++;
    if (DIGITS !== 16'h3210 || frames != f0 + 1) begin
      errors++;
      $display("FAIL frame_1 got %h pulses %0d want 3210 pulses 1",
               DIGITS, frames - f0);
    end
    for (int i = 0; i < 4; i++)
      drive(4'(1 << i), pat[i], 1'b1, 6);
    checks++;
    if (frames != f0 + 2) begin
      errors++;
      $display("FAIL frame_2 got %0d pulses want 2", frames - f0);
    end
  endtask

  task automatic test_select_en();
    drive(4'b0011, 7'h6D, 1'b1, 10);
    drive(4'b0000, 7'h6D, 1'b1, 10);
    checks++;
    if (DIGITS !== 16'h3210) begin
      errors++;
      $display("FAIL bad_select got %h want 3210", DIGITS);
    end
    drive(4'b1000, 7'h6D, 1'b0, 10);
    checks++;
    if (DIGITS !== 16'h3210) begin
      errors++;
      $display("FAIL en_hold got %h want 3210", DIGITS);
    end
    drive(4'b1000, 7'h6D, 1'b1, 6);
    checks++;
    if (DIGITS !== 16'h5210) begin
      errors++;
      $display("FAIL en_resume got %h want 5210", DIGITS);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    test_reset();
    test_sweep();
    test_glitch();
    test_illegal();
    test_frame();
    test_select_en();
    drive(4'b0000, 7'h00, 1'b1, 3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending got %0d entries want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
